// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller.
// Drives the enable/flush pair of the IF/ID, ID/EX, EX/MEM and MEM/WB latches
// plus the PC enable. It resolves, highest priority first: halted freeze, halt
// drain, data-memory wait, EX redirect, load-use, and fetch miss.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
//
// Handshake contract: this block has no valid/ready channels. Every output is
// a level that is valid for the current cycle only. It is combinational from
// the registered FSM state plus this cycle's inputs, and the latches sample it
// on the next rising CLK edge.
module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int HALT_DRAIN = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    input  logic             idex_dREN,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rt_used,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [1:0]       dbgState
`ifdef HAZARD_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } stateT;

    // Counter wide enough to reach HALT_DRAIN without wrapping.
    localparam int               CNT_W      = $clog2(HALT_DRAIN + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(HALT_DRAIN - 1);

    stateT            state;
    stateT            stateNext;
    logic             redirPend;
    logic             redirPendNext;
    logic [CNT_W-1:0] drainCnt;
    logic [CNT_W-1:0] drainCntNext;

    logic memWait;
    logic loadUse;
    logic redirAct;
    logic drainAct;

    // Hazard conditions seen this cycle. Register 0 never causes a stall.
    assign memWait  = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign loadUse  = idex_dREN & (idex_rd != '0) &
                      ((idex_rd == ifid_rs) | (ifid_rt_used & (idex_rd == ifid_rt)));
    assign redirAct = ex_redirect | redirPend;
    // The halt cycle itself already drains, unless a data access must finish first.
    assign drainAct = (state == DRAIN) |
                      ((state != HALTED) & exmem_halt & ~memWait);

    assign dbgState = state;

    // State register: FSM state, pending-redirect flag and drain counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            redirPend <= 1'b0;
            drainCnt  <= '0;
        end else begin
            state     <= stateNext;
            redirPend <= redirPendNext;
            drainCnt  <= drainCntNext;
        end
    end

    // Next-state logic in strict priority order.
    always_comb begin
        stateNext     = state;
        redirPendNext = redirPend;
        drainCntNext  = drainCnt;
        if (state == HALTED) begin
            stateNext = HALTED;
        end else if (drainAct) begin
            drainCntNext = drainCnt + CNT_W'(1);
            stateNext    = (drainCnt == DRAIN_LAST) ? HALTED : DRAIN;
        end else if (memWait) begin
            stateNext = MEMWAIT;
        end else begin
            // The dhit cycle of a memory wait behaves as RUN.
            stateNext = RUN;
            // A redirect that has no fetch yet keeps flushing IF/ID until the icache hits.
            if (redirAct) begin
                redirPendNext = ~ihit;
            end
        end
    end

    // Latch enable/flush outputs in strict priority order.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
        end else if (drainAct) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (memWait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (redirAct) begin
            // Redirect overrides load-use: the wrong-path instructions are squashed anyway.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loadUse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating stall and flush counters with synchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (state != HALTED) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (idex_flush && (flush_events != 32'hFFFF_FFFF)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// The output vector order is {pc, ifid_en, idex_en, exmem_en, memwb_en,
// ifid_f, idex_f, exmem_f, memwb_f, halted}.
module tb_hazard_ctrl;

    localparam int HD = 2;

    localparam logic [9:0] O_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] O_LU    = 10'b00111_0100_0;
    localparam logic [9:0] O_MW    = 10'b00001_0001_0;
    localparam logic [9:0] O_REDIR = 10'b11111_1100_0;
    localparam logic [9:0] O_FMISS = 10'b01111_1000_0;
    localparam logic [9:0] O_DRAIN = 10'b00001_0000_0;
    localparam logic [9:0] O_HALT  = 10'b00000_0000_1;
    localparam logic [9:0] O_RST   = 10'b00000_1111_0;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic       ldr;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rtu;
        logic       redir;
    } stimT;

    typedef struct packed {
        stimT       s;
        logic [9:0] exp;
    } vecT;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, idex_dREN;
    logic [4:0] idex_rd, ifid_rs, ifid_rt;
    logic       ifid_rt_used, ex_redirect;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [1:0] dbgState;
`ifdef HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] stall_cycles, flush_events;
`endif

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REG_W(5), .HALT_DRAIN(HD)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
        .idex_dREN(idex_dREN), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rt_used(ifid_rt_used), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
        .dbgState(dbgState)
`ifdef HAZARD_PERF_EN
        , .perf_clr(perf_clr), .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    int         errCount = 0;
    int         checkCount = 0;

    // ---------------- reference model ----------------
    // Tracks only what the rules need: frozen, drain cycles still to run, redirect pending.
    logic mHalted;
    int   mDrainLeft;
    logic mPend;

    task automatic modelReset();
        mHalted    = 1'b0;
        mDrainLeft = 0;
        mPend      = 1'b0;
    endtask

    function automatic logic [9:0] modelOut(input stimT s);
        logic mw, lu;
        mw = (s.dren | s.dwen) & ~s.dhit;
        lu = s.ldr && s.rd != 0 && (s.rd == s.rs || (s.rtu && s.rd == s.rt));
        if (mHalted)                         return O_HALT;
        if (mDrainLeft > 0 || (s.halt && !mw)) return O_DRAIN;
        if (mw)                              return O_MW;
        if (s.redir || mPend)                return O_REDIR;
        if (lu)                              return O_LU;
        if (!s.ihit)                         return O_FMISS;
        return O_RUN;
    endfunction

    task automatic modelAdvance(input stimT s);
        logic mw;
        mw = (s.dren | s.dwen) & ~s.dhit;
        if (mHalted) begin
        end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mHalted = 1'b1;
        end else if (s.halt && !mw) begin
            mDrainLeft = HD - 1;
            if (mDrainLeft == 0) mHalted = 1'b1;
        end else if (!mw && (s.redir || mPend)) begin
            mPend = ~s.ihit;
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic stimT mk(input logic ih, dh, dr, dw, hl, ld,
                                input logic [4:0] rd, rs, rt, input logic rtu, rdr);
        stimT s;
        s.ihit = ih; s.dhit = dh; s.dren = dr; s.dwen = dw; s.halt = hl; s.ldr = ld;
        s.rd = rd; s.rs = rs; s.rt = rt; s.rtu = rtu; s.redir = rdr;
        return s;
    endfunction

    task automatic drive(input stimT s);
        ihit = s.ihit; dhit = s.dhit; exmem_dREN = s.dren; exmem_dWEN = s.dwen;
        exmem_halt = s.halt; idex_dREN = s.ldr; idex_rd = s.rd; ifid_rs = s.rs;
        ifid_rt = s.rt; ifid_rt_used = s.rtu; ex_redirect = s.redir;
    endtask

    function automatic logic [9:0] dutOut();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};
    endfunction

    task automatic checkVal(input string name, input int idx,
                            input logic [9:0] got, input logic [9:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // One cycle: drive after the rising edge, compare at the falling edge.
    task automatic step(input stimT s, input logic [9:0] exp, input string name, input int idx);
        drive(s);
        exp_q.push_back(exp);
        @(negedge CLK);
        checkVal(name, idx, dutOut(), exp_q.pop_front());
        modelAdvance(s);
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0));
        #1;
        checkVal("reset", 0, dutOut(), O_RST);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        modelReset();
    endtask

    // ---------------- test ----------------
    vecT  vecs[19];
    stimT idle, mwS, hS, r;

    initial begin
        idle = mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0);
        mwS  = mk(1, 0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
        hS   = mk(1, 1, 0, 0, 1, 0, 0, 1, 2, 1, 0);

        vecs[0]  = '{idle, O_RUN};
        vecs[1]  = '{mk(1, 1, 0, 0, 0, 1, 5, 5, 2, 1, 0), O_LU};
        vecs[2]  = '{idle, O_RUN};
        vecs[3]  = '{mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0), O_RUN};
        vecs[4]  = '{mk(1, 1, 0, 0, 0, 1, 7, 1, 7, 1, 0), O_LU};
        vecs[5]  = '{mk(1, 1, 0, 0, 0, 1, 7, 1, 7, 0, 0), O_RUN};
        vecs[6]  = '{mwS, O_MW};
        vecs[7]  = '{mwS, O_MW};
        vecs[8]  = '{mwS, O_MW};
        vecs[9]  = '{mk(1, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0), O_RUN};
        vecs[10] = '{mk(1, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0), O_MW};
        vecs[11] = '{mk(1, 1, 0, 1, 0, 0, 0, 1, 2, 1, 0), O_RUN};
        vecs[12] = '{mk(0, 1, 0, 0, 0, 1, 5, 5, 2, 1, 1), O_REDIR};
        vecs[13] = '{mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0), O_REDIR};
        vecs[14] = '{idle, O_REDIR};
        vecs[15] = '{idle, O_RUN};
        vecs[16] = '{mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0), O_FMISS};
        vecs[17] = '{mk(1, 0, 1, 0, 0, 0, 0, 1, 2, 1, 1), O_MW};
        vecs[18] = '{idle, O_RUN};

        drive(idle);
        modelReset();
        @(posedge CLK);
        #1;
        doReset();

        // Table of single-cycle and short multi-cycle patterns from RUN.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].s, vecs[i].exp, "vec", i);
        end

        // Halt drain: two MEM/WB advance cycles, then frozen regardless of inputs.
        doReset();
        step(idle, O_RUN, "halt", 0);
        step(hS, O_DRAIN, "halt", 1);
        step(hS, O_DRAIN, "halt", 2);
        step(hS, O_HALT, "halt", 3);
        step(mk(0, 0, 1, 0, 1, 1, 5, 5, 2, 1, 1), O_HALT, "halt", 4);
        step(idle, O_HALT, "halt", 5);

        // Asynchronous reset in the middle of a memory wait.
        doReset();
        step(mwS, O_MW, "rstmw", 0);
        step(mwS, O_MW, "rstmw", 1);
        drive(mwS);
        #2;
        checkVal("rstmw_state", 0, {8'd0, dbgState}, 10'd1);
        nRST = 1'b0;
        #1;
        checkVal("rstmw_async", 0, dutOut(), O_RST);
        checkVal("rstmw_state", 1, {8'd0, dbgState}, 10'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        modelReset();
        step(idle, O_RUN, "rstmw", 2);
        checkVal("rstmw_state", 2, {8'd0, dbgState}, 10'd0);

        // Reset clears a pending redirect: a later fetch miss is a plain miss.
        doReset();
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 1), O_REDIR, "rstpend", 0);
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0), O_REDIR, "rstpend", 1);
        doReset();
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0), O_FMISS, "rstpend", 2);

`ifdef HAZARD_PERF_EN
        // Load-use then memory wait: four stall cycles, one ID/EX flush.
        doReset();
        step(mk(1, 1, 0, 0, 0, 1, 5, 5, 2, 1, 0), O_LU, "perf", 0);
        step(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0), O_RUN, "perf", 1);
        step(mwS, O_MW, "perf", 2);
        step(mwS, O_MW, "perf", 3);
        step(mwS, O_MW, "perf", 4);
        step(mk(1, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0), O_RUN, "perf", 5);
        checkVal("perf_stall", 0, stall_cycles[9:0], 10'd4);
        checkVal("perf_flush", 0, flush_events[9:0], 10'd1);
        perf_clr = 1'b1;
        step(mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0), O_FMISS, "perf", 6);
        perf_clr = 1'b0;
        checkVal("perf_clr_stall", 0, stall_cycles[9:0], 10'd0);
        checkVal("perf_clr_flush", 0, flush_events[9:0], 10'd0);
`endif

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            r = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 5) == 0);
            step(r, modelOut(r), "rand", i);
            if (mHalted && $urandom_range(0, 2) == 0) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and stall controller that drives the en/flush inputs of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Its inputs are the latch outputs and the cache hit signals.
- It resolves four hazard classes:
  - load-use
  - data-memory wait
  - control redirect from EX
  - halt drain
- A small FSM holds any condition that spans more than one cycle.

Parameters:
- REG_W, 5, register index width.
- HALT_DRAIN, 2, cycles of MEM/WB advance after halt is seen in EX/MEM before full freeze.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache hit for the current fetch.
- dhit  in  1  dcache hit for the EX/MEM access.
- exmem_dREN  in  1  EX/MEM load pending.
- exmem_dWEN  in  1  EX/MEM store pending.
- exmem_halt  in  1  halt instruction has reached EX/MEM.
- idex_dREN  in  1  ID/EX instruction is a load.
- idex_rd  in  REG_W  ID/EX destination register.
- ifid_rs  in  REG_W  IF/ID source register 1.
- ifid_rt  in  REG_W  IF/ID source register 2.
- ifid_rt_used  in  1  IF/ID instruction reads rt.
- ex_redirect  in  1  branch taken or jump resolved in EX (pcSrc != sequential).
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes (insert bubble).
- halted  out  1  pipeline fully frozen after halt.

Behaviour:
- Clock and reset: one clock (CLK); nRST asynchronous active-low.
- Reset values, while nRST = 0:
  - state = RUN, redir_pend = 0, drain_cnt = 0.
  - All *_en = 0, all *_flush = 1, halted = 0.
- Output timing: outputs are combinational from registered state plus current inputs.
- The same-cycle priority order below is strict (highest first).
- FSM states:
  - RUN: normal operation.
  - MEMWAIT: data access outstanding.
  - DRAIN: halt is flowing to WB.
  - HALTED: frozen.
- 1. HALTED:
  - All en = 0, all flush = 0, halted = 1.
  - Leaves only on reset.
- 2. DRAIN:
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_en = 1.
  - drain_cnt increments each cycle; at drain_cnt == HALT_DRAIN-1, next state = HALTED.
  - Entered from RUN when exmem_halt = 1 and no memory wait is pending.
- 3. Memory wait, (exmem_dREN | exmem_dWEN) & ~dhit:
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_en = 1 and memwb_flush = 1.
  - state = MEMWAIT; returns to RUN in the cycle after dhit = 1.
  - The dhit cycle itself behaves as RUN.
- 4. Redirect, ex_redirect = 1 or redir_pend = 1:
  - ifid_flush = 1, idex_flush = 1, pc_en = 1; exmem and memwb enabled.
  - If ihit = 0 in the redirect cycle, set redir_pend.
  - redir_pend holds ifid_flush = 1 every cycle until the first ihit = 1, then clears.
  - Redirect overrides load-use in the same cycle.
- 5. Load-use:
  - Condition: idex_dREN & idex_rd != 0 & (idex_rd == ifid_rs | (ifid_rt_used & idex_rd == ifid_rt)).
  - pc_en = 0, ifid_en = 0, idex_flush = 1; exmem and memwb enabled.
  - Lasts exactly one cycle, since the bubble clears idex_dREN.
- 6. Fetch miss, ihit = 0:
  - pc_en = 0 and ifid_flush = 1; downstream latches enabled.
- 7. Otherwise:
  - All en = 1, all flush = 0.
- Register 0 never causes a stall.
- Reset mid-MEMWAIT or mid-DRAIN returns to RUN immediately and clears redir_pend.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three ports:
  - stall_cycles  out 32: counts cycles with pc_en = 0 while not HALTED.
  - flush_events  out 32: counts cycles with idex_flush = 1 outside reset.
  - perf_clr  in 1: synchronous clear of both counters.
- Counters saturate at 32'hFFFFFFFF and reset to 0 on nRST.
- When undefined, these ports and the logic behind them do not exist.

Test Plan:
- Load-use: idex_dREN = 1, idex_rd = 5, ifid_rs = 5, ihit = 1, dhit = 1 -> for one cycle pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1. Same stimulus with idex_rd = 0 -> no stall.
- Memory wait: exmem_dREN = 1 with dhit = 0 for 3 cycles, then 1 -> pc/ifid/idex/exmem enables low for 3 cycles and memwb_flush = 1 in each of them; RUN outputs in the dhit cycle.
- Redirect with ex_redirect = 1 and ihit = 0 for 2 cycles -> ifid_flush = 1 for 3 cycles (redirect cycle plus pend), clearing after the first ihit = 1. Simultaneous load-use in the redirect cycle -> redirect wins (pc_en = 1).
- Halt: exmem_halt = 1 at cycle t -> memwb_en = 1 only for t..t+1, halted = 1 from t+2 onward, all enables 0 and held.
- Reset: assert nRST low during MEMWAIT -> outputs go to reset values asynchronously; after release, state = RUN.
- With HAZARD_PERF_EN defined: after the first two scenarios, stall_cycles = 4 and flush_events = 1; perf_clr -> both 0 next cycle.
